note_display_mux: RTL and testbench

NOTE_DISPLAY_MUX -- requirements
Module: note_display_mux

---
 rtl/note_disp_pkg.sv | 29 ++
 rtl/note_seg_lut.sv | 29 ++
 rtl/note_display_mux.sv | 118 +++++++++++
 tb/tb_note_display_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_disp_pkg.sv
// Shared constants for the note display: note codes, segment patterns
// ({g,f,e,d,c,b,a}, active-low) and the history entry type.
package note_disp_pkg;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_A    = 3'd1;
  localparam logic [2:0] NOTE_B    = 3'd2;
  localparam logic [2:0] NOTE_C    = 3'd3;
  localparam logic [2:0] NOTE_D    = 3'd4;
  localparam logic [2:0] NOTE_E    = 3'd5;
  localparam logic [2:0] NOTE_F    = 3'd6;
  localparam logic [2:0] NOTE_G    = 3'd7;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       occ;
    logic [2:0] code;
  } hist_entry_t;

endpackage

// File: rtl/note_seg_lut.sv
// Combinational note-code to seven-segment pattern lookup.
// Unoccupied slots are blank; an occupied "none" code shows a dash.
module note_seg_lut
  import note_disp_pkg::*;
(
  input  logic [2:0] code,
  input  logic       occupied,
  output logic [6:0] seg
);

  // Pattern select; blank unless the slot holds a note
  always_comb begin
    seg = SEG_BLANK;
    if (occupied) begin
      case (code)
        NOTE_NONE: seg = SEG_DASH;
        NOTE_A:    seg = SEG_A;
        NOTE_B:    seg = SEG_B;
        NOTE_C:    seg = SEG_C;
        NOTE_D:    seg = SEG_D;
        NOTE_E:    seg = SEG_E;
        NOTE_F:    seg = SEG_F;
        NOTE_G:    seg = SEG_G;
        default:   seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/note_display_mux.sv
// Note history display: shifts accepted notes into a NUM_DIGITS-deep
// history (entry 0 newest, rightmost digit) and time-multiplexes it onto
// a common seven-segment display. seg and an are registered from the
// same next-state index/contents so they always change together.
module note_display_mux
  import note_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2:0]                        note_in,
  input  logic                              note_valid,
  output logic                              note_ready,
  input  logic                              freeze,
  input  logic                              clear,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   fill_count
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(NUM_DIGITS+1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         fill_q, fill_d;
  hist_entry_t           hist_q [NUM_DIGITS];
  hist_entry_t           hist_d [NUM_DIGITS];
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  accept;
  logic                  tick;
  hist_entry_t           sel_entry;
  logic [NUM_DIGITS-1:0] an_one;

  assign note_ready = !freeze && !rst;
  assign accept     = note_valid && note_ready;
  assign an_one     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  // Prescaler and digit index; scanning runs regardless of freeze
  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV-1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IW'(NUM_DIGITS-1)) ? '0 : idx_q + IW'(1);
    end
  end

  // History shift on accept; clear wins and drops a simultaneous note
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        hist_d[k] = '0;
      end
      fill_d = '0;
    end else if (accept) begin
      for (int k = NUM_DIGITS-1; k > 0; k--) begin
        hist_d[k] = hist_q[k-1];
      end
      hist_d[0] = '{occ: 1'b1, code: note_in};
      if (fill_q != FW'(NUM_DIGITS)) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  // Pick the entry that the next index will show, from next-cycle contents
  always_comb begin
    sel_entry = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        sel_entry = hist_d[k];
      end
    end
    an_d = ~(an_one << idx_d);
  end

  note_seg_lut u_lut (
    .code     (sel_entry.code),
    .occupied (sel_entry.occ),
    .seg      (seg_d)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        hist_q[k] <= '0;
      end
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        hist_q[k] <= hist_d[k];
      end
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_note_display_mux.sv
// Bench for note_display_mux: a queue-based history model plus an
// edge-count scan model predict seg/an/fill_count/note_ready every cycle;
// directed scenarios add literal expectations.
module tb_note_display_mux;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int FW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    note_in = '0;
  logic          note_valid = 1'b0;
  logic          note_ready;
  logic          freeze = 1'b0;
  logic          clear = 1'b0;
  logic [6:0]    seg;
  logic [N-1:0]  an;
  logic [FW-1:0] fill_count;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] seg_tab [8] = '{7'b0111111, 7'b0001000, 7'b0000011, 7'b1000110,
                              7'b0100001, 7'b0000110, 7'b0001110, 7'b1000010};

  note_display_mux #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .note_in    (note_in),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .freeze     (freeze),
    .clear      (clear),
    .seg        (seg),
    .an         (an),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: history as a queue (front = newest), scan index from
  // the number of clocks since reset release.
  int         hist[$];
  int         edges = 0;
  bit         model_live = 1'b0;
  logic [6:0] exp_seg;
  logic [N-1:0] exp_an;
  int         exp_fill;

  always @(posedge clk) begin
    int d;
    logic [N-1:0] one;
    one = 1;
    if (rst) begin
      hist.delete();
      edges      = 0;
      model_live = 1'b1;
      exp_seg    = BLANK;
      exp_an     = '1;
      exp_fill   = 0;
    end else begin
      if (clear) hist.delete();
      else if (note_valid && !freeze) begin
        hist.push_front(int'(note_in));
        if (hist.size() > N) void'(hist.pop_back());
      end
      edges++;
      d        = (edges / S) % N;
      exp_an   = ~(one << d);
      exp_seg  = (d < hist.size()) ? seg_tab[hist[d]] : BLANK;
      exp_fill = hist.size();
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("seg", int'(seg), int'(exp_seg));
      check("an", int'(an), int'(exp_an));
      check("fill_count", int'(fill_count), exp_fill);
      check("note_ready", int'(note_ready), int'(!freeze && !rst));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int code);
    note_valid = 1'b1;
    note_in    = 3'(code);
    step();
    note_valid = 1'b0;
  endtask

  task automatic wait_an(input logic [N-1:0] target);
    for (int i = 0; i < 8*N*S; i++) begin
      @(negedge clk);
      if (an == target) return;
    end
    check("wait_an_timeout", int'(an), int'(target));
  endtask

  task automatic expect_digit(input int d, input logic [6:0] lit, input string name);
    logic [N-1:0] one;
    one = 1;
    wait_an(~(one << d));
    check(name, int'(seg), int'(lit));
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_an_hold", int'(an), 'hF);
    @(negedge clk);
    check("first_an", int'(an), 'hE);
    check("first_seg", int'(seg), int'(BLANK));
    repeat (20) step();
    check("idle_fill", int'(fill_count), 0);

    // Three notes C, D, E
    send(3); send(4); send(5);
    expect_digit(0, 7'b0000110, "c3_d0");
    expect_digit(1, 7'b0100001, "c3_d1");
    expect_digit(2, 7'b1000110, "c3_d2");
    expect_digit(3, BLANK,      "c3_d3");
    check("c3_fill", int'(fill_count), 3);

    // Six notes A..F, A and B fall off
    clear = 1'b1; step(); clear = 1'b0;
    for (int c = 1; c <= 6; c++) send(c);
    expect_digit(0, 7'b0001110, "c6_d0");
    expect_digit(1, 7'b0000110, "c6_d1");
    expect_digit(2, 7'b0100001, "c6_d2");
    expect_digit(3, 7'b1000110, "c6_d3");
    check("c6_fill", int'(fill_count), 4);

    // Freeze refuses notes, then clear under freeze
    freeze = 1'b1;
    note_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      note_in = 3'($urandom_range(0, 7));
      step();
    end
    note_valid = 1'b0;
    check("frz_fill", int'(fill_count), 4);
    expect_digit(0, 7'b0001110, "frz_d0");
    step();
    clear = 1'b1; step(); clear = 1'b0;
    @(negedge clk);
    check("frz_clr_fill", int'(fill_count), 0);
    expect_digit(3, BLANK, "frz_clr_d3");
    step();
    freeze = 1'b0;

    // Clear beats simultaneous accept; code 0 shows a dash
    clear = 1'b1; note_valid = 1'b1; note_in = 3'd7; step();
    clear = 1'b0; note_valid = 1'b0;
    @(negedge clk);
    check("clr_acc_fill", int'(fill_count), 0);
    expect_digit(0, BLANK, "clr_acc_d0");
    step();
    send(0);
    expect_digit(0, 7'b0111111, "dash_d0");
    check("dash_fill", int'(fill_count), 1);

    // Accept in the last cycle before digit 0's slot shows immediately
    step();
    clear = 1'b1; step(); clear = 1'b0;
    wait_an(4'b1110);
    wait_an(4'b0111);
    repeat (3) @(posedge clk);
    #1;
    note_valid = 1'b1; note_in = 3'd2;
    step();
    note_valid = 1'b0;
    @(negedge clk);
    check("edge_an", int'(an), 'hE);
    check("edge_seg", int'(seg), int'(7'b0000011));

    // Reset pulse at index 2 with three notes held
    step();
    send(1); send(2); send(3);
    wait_an(4'b1011);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    check("rstp_an", int'(an), 'hF);
    check("rstp_fill", int'(fill_count), 0);
    @(negedge clk);
    check("rstp_an2", int'(an), 'hE);
    check("rstp_seg2", int'(seg), int'(BLANK));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      note_valid = 1'($urandom_range(0, 1));
      note_in    = 3'($urandom_range(0, 7));
      freeze     = ($urandom_range(0, 7) == 0);
      clear      = ($urandom_range(0, 31) == 0);
      rst        = ($urandom_range(0, 299) == 0);
    end
    step();
    note_valid = 1'b0; freeze = 1'b0; clear = 1'b0; rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
